cic_decimator: RTL and testbench

Four-stage cascaded integrator-comb (CIC) decimator for one real 16-bit channel of the receive chain. It sits after the CORDIC down-converter, with one instance per I/Q rail per channel. Integrators run at the input sample strobe. Combs run at an externally supplied decimated strobe. Bit growth is removed by a rate-dependent shifter, so DC gain is ≤1.

---
 rtl/cic_decimator.sv | 92 +++++++++
 tb/tb_cic_decimator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// Four-stage CIC decimator: integrators on strobe_in, combs on strobe_out, rate-dependent shift to unity-or-less DC gain.
// Optional macro CIC_DECIM_ROUND_EN selects round-half-up in the output shifter instead of truncation.
module cic_decimator #(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    rate,
  input  logic          strobe_in,
  input  logic          strobe_out,
  input  logic [bw-1:0] signal_in,
  output logic [bw-1:0] signal_out
);

  localparam int W         = bw + N * log2_of_max_rate;
  localparam int max_shift = N * log2_of_max_rate;
  localparam int sw        = $clog2(max_shift + 1);

  // Smallest s with 2^s >= r^N, i.e. ceil(N*log2(r)); rate 0 behaves as 1.
  function automatic int calc_shift(input int r);
    longint p;
    int     res;
    p   = 1;
    res = max_shift;
    if (r <= 1) begin
      res = 0;
    end else if (r <= (1 << log2_of_max_rate)) begin
      for (int k = 0; k < N; k++) p = p * longint'(r);
      for (int k = max_shift; k >= 0; k--) begin
        if ((longint'(1) << k) >= p) res = k;
      end
    end
    return res;
  endfunction

  logic [sw-1:0] shift_lut [256];

  generate
    for (genvar gi = 0; gi < 256; gi++) begin : g_shift_lut
      assign shift_lut[gi] = sw'(calc_shift(gi));
    end
  endgenerate

  logic [sw-1:0]       shift;
  logic signed [W-1:0] ext;
  logic signed [W-1:0] integ_reg [N];
  logic signed [W-1:0] dly_reg   [N];
  logic signed [W-1:0] comb_reg  [N];
  logic signed [W-1:0] biased;
  logic [bw-1:0]       result;

  assign shift = shift_lut[rate];
  assign ext   = {{(W - bw){signal_in[bw-1]}}, signal_in};

`ifdef CIC_DECIM_ROUND_EN
  assign biased = comb_reg[N-1] + ((shift == '0) ? '0 : (W'(1) << (shift - 1'b1)));
`else
  assign biased = comb_reg[N-1];
`endif

  assign result = bw'(biased >>> shift);

  // Every stage reads pre-edge values, so the cascade is one strobe deep per stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ_reg[k] <= '0;
        dly_reg[k]   <= '0;
        comb_reg[k]  <= '0;
      end
      signal_out <= '0;
    end else if (enable) begin
      if (strobe_in) begin
        integ_reg[0] <= integ_reg[0] + ext;
        for (int k = 1; k < N; k++) integ_reg[k] <= integ_reg[k] + integ_reg[k-1];
      end
      if (strobe_out) begin
        dly_reg[0]  <= integ_reg[N-1];
        comb_reg[0] <= integ_reg[N-1] - dly_reg[0];
        for (int k = 1; k < N; k++) begin
          dly_reg[k]  <= comb_reg[k-1];
          comb_reg[k] <= comb_reg[k-1] - dly_reg[k];
        end
        signal_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: closed-form binomial reference model plus directed DC, gating and random runs.
module tb_cic_decimator;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rate;
  logic        strobe_in;
  logic        strobe_out;
  logic [15:0] signal_in;
  logic [15:0] signal_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: accepted input samples, I3 values seen at each output strobe, expected output.
  logic [63:0] smp_q [$];
  logic [63:0] x_q   [$];
  logic [15:0] exp_out;

  cic_decimator dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .strobe_out (strobe_out),
    .signal_in  (signal_in),
    .signal_out (signal_out)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] binom3(input longint k);
    if (k < 3) return 64'd0;
    return 64'(k * (k - 1) * (k - 2) / 6);
  endfunction

  // Fourth-order integrator after n samples: sum of s[j] * C(n-1-j, 3).
  function automatic logic [63:0] i3_now();
    logic [63:0] acc;
    int          n;
    acc = 64'd0;
    n   = smp_q.size();
    for (int j = 0; j < n; j++) acc = acc + smp_q[j] * binom3(longint'(n - 1 - j));
    return acc;
  endfunction

  // Fourth difference of the decimated integrator sequence, zero before the first sample.
  function automatic logic [63:0] delta4(input int j);
    longint      c [5];
    logic [63:0] acc;
    c   = '{1, -4, 6, -4, 1};
    acc = 64'd0;
    for (int t = 0; t < 5; t++) begin
      if (j - t >= 0) acc = acc + 64'(c[t]) * x_q[j - t];
    end
    return acc;
  endfunction

  function automatic logic [15:0] model_shift(input logic [63:0] v, input int r);
    int     s;
    longint sv;
    if (r <= 1)        s = 0;
    else if (r > 128)  s = 28;
    else               s = $clog2(longint'(r) * r * r * r);
    sv = $signed(v << 20) >>> 20;
`ifdef CIC_DECIM_ROUND_EN
    if (s > 0) sv = sv + (longint'(1) << (s - 1));
`endif
    sv = sv >>> s;
    return sv[15:0];
  endfunction

  task automatic step(input bit rst, input bit en, input bit si, input bit so, input logic [15:0] x);
    int m;
    reset      = rst;
    enable     = en;
    strobe_in  = si;
    strobe_out = so;
    signal_in  = x;
    if (rst) begin
      smp_q.delete();
      x_q.delete();
      exp_out = 16'd0;
    end else if (en) begin
      if (so) begin
        x_q.push_back(i3_now());
        m       = x_q.size() - 1;
        exp_out = model_shift(delta4(m - 4), int'(rate));
      end
      if (si) smp_q.push_back({{48{x[15]}}, x});
    end
    @(posedge clock);
    #1;
  endtask

  // Continuous input, one output strobe per R input strobes; checks model every cycle and the DC value once settled.
  task automatic run_dc(input int r, input logic [15:0] value, input int n_events,
                        input logic [15:0] exp_const, input string name);
    int  ev;
    bit  so;
    rate = 8'(r);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    ev = 0;
    for (int cyc = 0; ev < n_events; cyc++) begin
      so = ((cyc % r) == r - 1);
      step(1'b0, 1'b1, 1'b1, so, value);
      if (so) ev++;
      n_cmp++;
      if (signal_out !== exp_out) begin
        n_bad++;
        $display("FAIL %s_model cyc=%0d: got %0d expected %0d", name, cyc, $signed(signal_out), $signed(exp_out));
      end
      if (so && ev >= 10) begin
        $display("%s R=%0d event=%0d out=%0d", name, r, ev, $signed(signal_out));
        n_cmp++;
        if (signal_out !== exp_const) begin
          n_bad++;
          $display("FAIL %s_dc event=%0d: got %0d expected %0d", name, ev, $signed(signal_out), $signed(exp_const));
        end
      end
    end
  endtask

  task automatic test_reset();
    rate = 8'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    n_cmp++;
    if (signal_out !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_initial: got %0d expected 0", $signed(signal_out));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'd12345);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      n_cmp++;
      if (signal_out !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d: got %0d expected 0", i, $signed(signal_out));
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    n_cmp++;
    if (signal_out !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_release: got %0d expected 0", $signed(signal_out));
    end
  endtask

  task automatic test_dc_gain();
    logic [15:0] exp3;
`ifdef CIC_DECIM_ROUND_EN
    exp3 = 16'd633;
`else
    exp3 = 16'd632;
`endif
    run_dc(4, 16'd1000, 12, 16'd1000, "dc_r4_pos");
    run_dc(4, -16'sd1000, 12, -16'sd1000, "dc_r4_neg");
    run_dc(3, 16'd1000, 12, exp3, "dc_r3");
  endtask

  task automatic test_rate_extremes();
    run_dc(1, 16'd12345, 14, 16'd12345, "rate_r1");
    run_dc(128, 16'h8000, 12, 16'h8000, "rate_r128");
  endtask

  task automatic test_enable_gating();
    bit so;
    rate = 8'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int cyc = 0; cyc < 64; cyc++) begin
      so = (cyc % 2) == 1;
      if (cyc >= 24 && cyc < 44) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
      else                       step(1'b0, 1'b1, 1'b1, so, 16'd500);
      n_cmp++;
      if (signal_out !== exp_out) begin
        n_bad++;
        $display("FAIL gate_model cyc=%0d: got %0d expected %0d", cyc, $signed(signal_out), $signed(exp_out));
      end
      if (cyc >= 22) begin
        n_cmp++;
        if (signal_out !== 16'd500) begin
          n_bad++;
          $display("FAIL gate_hold cyc=%0d: got %0d expected 500", cyc, $signed(signal_out));
        end
      end
    end
  endtask

  task automatic test_coincident();
    run_dc(2, 16'd777, 12, 16'd777, "coincident_r2");
  endtask

  task automatic test_random();
    int  r;
    int  cnt;
    bit  en;
    bit  si;
    bit  so;
    rate = 8'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int seg = 0; seg < 3; seg++) begin
      r    = $urandom_range(1, 12);
      rate = 8'(r);
      cnt  = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        en = ($urandom_range(0, 9) != 0);
        si = ($urandom_range(0, 3) != 0);
        if (en) so = si && ((cnt % r) == r - 1);
        else    so = 1'($urandom);
        if (en && si) cnt++;
        step(1'b0, en, si, so, 16'($urandom));
        n_cmp++;
        if (signal_out !== exp_out) begin
          n_bad++;
          $display("FAIL random_r%0d cyc=%0d: got %0d expected %0d", r, cyc, $signed(signal_out), $signed(exp_out));
        end
      end
      $display("random segment %0d R=%0d outputs=%0d", seg, r, x_q.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    rate       = 8'd1;
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
    signal_in  = 16'd0;
    exp_out    = 16'd0;
    test_reset();
    test_dc_gain();
    test_rate_extremes();
    test_enable_gating();
    test_coincident();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
